seq_detect_ctrl: RTL and testbench

Programmable serial sequence-detector controller for the 7-segment demo tile.
- Accepts a pattern of 1..MAX_LEN bits and sequences the flow configure -> arm -> detect (overlapping) -> count.
- Drives the 7-segment display with the hex match count and a stretched decimal-point hit indicator.
- Sits between the tile pin inputs and uo_out; replaces fixed-pattern detection with a configured, armed scheduler.

---
 rtl/seq_detect_ctrl_pkg.sv | 17 +
 rtl/seq_detect_ctrl_if.sv | 29 ++
 rtl/seq_detect_ctrl_hex_to_seg7.sv | 9 +
 rtl/seq_detect_ctrl.sv | 117 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and constants for the sequence-detector controller.
// Holds the FSM state encoding and the 7-segment glyph table (gfedcba, active-high).
package seq_ctrl_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Control/data/display bundle between the tile pins and the sequence detector.
// The master drives serial data, configuration and control pulses; the slave returns status and segments.
interface seq_detect_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN)
);
  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               arm;
  logic               disarm;
  logic               clr_count;
  logic               armed;
  logic               match;
  logic [3:0]         count;
  logic [7:0]         seg;

  modport master (
    output x, x_valid, cfg_load, cfg_pattern, cfg_len, arm, disarm, clr_count,
    input  armed, match, count, seg
  );

  modport slave (
    input  x, x_valid, cfg_load, cfg_pattern, cfg_len, arm, disarm, clr_count,
    output armed, match, count, seg
  );
endinterface

// File: rtl/seq_detect_ctrl_hex_to_seg7.sv
// Combinational hex digit to 7-segment glyph lookup; the parent registers the result.
module hex_to_seg7
  import seq_ctrl_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_GLYPH[val_i];
endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable overlapping serial sequence detector with saturating hit count
// and a 7-segment display showing the count plus a stretched hit indicator.
module seq_detect_ctrl #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned LEN_W       = $clog2(MAX_LEN),
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  seq_detect_ctrl_if.slave bus
);
  import seq_ctrl_pkg::*;

  localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [MAX_LEN-1:0] ONES = '1;

  state_t             state_q, state_d;
  logic               configured_q, configured_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [3:0]         count_q, count_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               match_q, armed_q;
  logic [7:0]         seg_q;
  logic [MAX_LEN-1:0] shifted_c, mask_c;
  logic               hit_c;
  logic [6:0]         glyph_c;

  // Next-state, detection, counting and dp-hold logic
  always_comb begin
    state_d      = state_q;
    configured_d = configured_q;
    pat_d        = pat_q;
    len_d        = len_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    count_d      = count_q;
    hold_d       = hold_q;

    shifted_c = {hist_q[MAX_LEN-2:0], bus.x};
    mask_c    = ONES >> (LEN_W'(MAX_LEN - 1) - len_q);
    // A disarm in the same cycle wins over any sample, so it never reports a hit
    hit_c     = (state_q == S_ARMED) && !bus.disarm && bus.x_valid &&
                (fill_q >= FILL_W'(len_q)) && (((shifted_c ^ pat_q) & mask_c) == '0);

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_load) begin
          pat_d        = bus.cfg_pattern;
          len_d        = bus.cfg_len;
          configured_d = 1'b1;
        end
        if (bus.arm && !bus.disarm && configured_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (bus.disarm) begin
          state_d = S_IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (bus.x_valid) begin
          hist_d = shifted_c;
          fill_d = (fill_q == FILL_W'(MAX_LEN)) ? fill_q : fill_q + FILL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.clr_count)                  count_d = 4'd0;
    else if (hit_c && count_q != 4'hF)  count_d = count_q + 4'd1;

    if (bus.disarm)          hold_d = '0;
    else if (hit_c)          hold_d = HOLD_W'(HOLD_CYCLES);
    else if (hold_q != '0)   hold_d = hold_q - HOLD_W'(1);
  end

  hex_to_seg7 u_glyph (
    .val_i (count_d),
    .seg_o (glyph_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      configured_q <= 1'b0;
      pat_q        <= '0;
      len_q        <= '0;
      hist_q       <= '0;
      fill_q       <= '0;
      count_q      <= 4'd0;
      hold_q       <= '0;
      match_q      <= 1'b0;
      armed_q      <= 1'b0;
      seg_q        <= {1'b0, SEG_DASH};
    end else begin
      state_q      <= state_d;
      configured_q <= configured_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      match_q      <= hit_c;
      armed_q      <= (state_d == S_ARMED);
      seg_q        <= (state_d == S_ARMED) ? {(hold_d != '0), glyph_c} : {1'b0, SEG_DASH};
    end
  end

  assign bus.armed = armed_q;
  assign bus.match = match_q;
  assign bus.count = count_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed and randomized bench for seq_detect_ctrl against a queue-based reference model.
module tb_seq_detect_ctrl;
  localparam int MAXL = 8;
  localparam int HOLD = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  seq_detect_ctrl_if #(.MAX_LEN(8), .LEN_W(3)) bus ();

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(3), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received bits kept as a queue, newest at the back
  bit         m_armed;
  bit         m_cfg;
  logic [7:0] m_pat;
  int         m_len;
  bit         hist[$];
  int         m_count;
  int         m_hold;
  bit         m_match;

  task automatic model_reset();
    m_armed = 0; m_cfg = 0; m_pat = '0; m_len = 0;
    hist.delete(); m_count = 0; m_hold = 0; m_match = 0;
  endtask

  task automatic model_tick(input logic xv, input logic xb, input logic ld, input logic [7:0] pat,
                            input logic [2:0] len, input logic a, input logic d, input logic c);
    bit hit;
    bit had_cfg;
    int L;
    hit = 0;
    if (m_armed && !d && xv) begin
      hist.push_back(xb);
      if (hist.size() > MAXL) void'(hist.pop_front());
      L = m_len + 1;
      if (hist.size() >= L) begin
        hit = 1;
        for (int i = 0; i < L; i++)
          if (hist[hist.size() - 1 - i] != m_pat[i]) hit = 0;
      end
    end
    m_match = hit;
    if (c) m_count = 0;
    else if (hit && m_count < 15) m_count++;
    if (d) m_hold = 0;
    else if (hit) m_hold = HOLD;
    else if (m_hold > 0) m_hold--;
    if (m_armed) begin
      if (d) begin m_armed = 0; hist.delete(); end
    end else begin
      had_cfg = m_cfg;
      if (ld) begin m_pat = pat; m_len = int'(len); m_cfg = 1; end
      if (a && !d && had_cfg) m_armed = 1;
    end
  endtask

  function automatic logic [7:0] exp_seg();
    if (!m_armed) return 8'h40;
    return {(m_hold > 0), GLYPH[m_count]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".match"}, {7'd0, bus.match}, {7'd0, m_match});
    chk({tag, ".count"}, {4'd0, bus.count}, 8'(m_count));
    chk({tag, ".armed"}, {7'd0, bus.armed}, {7'd0, m_armed});
    chk({tag, ".seg"},   bus.seg, exp_seg());
  endtask

  task automatic step(input string tag, input logic xv, input logic xb, input logic ld,
                      input logic [7:0] pat, input logic [2:0] len,
                      input logic a, input logic d, input logic c);
    bus.x = xb; bus.x_valid = xv; bus.cfg_load = ld; bus.cfg_pattern = pat;
    bus.cfg_len = len; bus.arm = a; bus.disarm = d; bus.clr_count = c;
    @(posedge clk);
    model_tick(xv, xb, ld, pat, len, a, d, c);
    #1;
    check_all(tag);
  endtask

  task automatic bit_in(input string tag, input logic b);
    step(tag, 1'b1, b, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge arrives
  task automatic reset_pulse(input string tag);
    #3 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] s1;
    logic [7:0] s2;
    n_pass = 0; n_total = 0;
    bus.x = 0; bus.x_valid = 0; bus.cfg_load = 0; bus.cfg_pattern = '0;
    bus.cfg_len = '0; bus.arm = 0; bus.disarm = 0; bus.clr_count = 0;
    reset = 1'b1;
    model_reset();
    #3 check_all("rst");
    @(negedge clk) reset = 1'b0;

    // Pattern 1011 with overlap
    step("a_cfg", 0, 0, 1, 8'h0B, 3'd3, 0, 0, 0);
    step("a_arm", 0, 0, 0, 8'h00, 3'd0, 1, 0, 0);
    s1 = 8'b0110_1101;
    for (int i = 0; i < 7; i++) bit_in("a_bit", s1[i]);
    chk("a_count2", {4'd0, bus.count}, 8'd2);
    chk("a_glyph2", {1'b0, bus.seg[6:0]}, 8'h5B);
    for (int i = 0; i < 5; i++) idle("a_dp");

    // Same pattern, gaps in x_valid
    step("b_dis", 0, 0, 0, 8'h00, 3'd0, 0, 1, 0);
    step("b_arm", 0, 0, 0, 8'h00, 3'd0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      bit_in("b_bit", s1[i]);
      step("b_gap", 0, ~s1[i], 0, 8'h00, 3'd0, 0, 0, 0);
    end

    // Mid-stream reset loses configuration; arm is then ignored
    reset_pulse("c_rst");
    step("c_arm_nocfg", 0, 0, 0, 8'h00, 3'd0, 1, 0, 0);
    chk("c_not_armed", {7'd0, bus.armed}, 8'd0);
    step("c_cfg", 0, 0, 1, 8'h0B, 3'd3, 0, 0, 0);
    step("c_arm", 0, 0, 0, 8'h00, 3'd0, 1, 0, 0);
    step("c_cfg_ign", 0, 0, 1, 8'hFF, 3'd0, 0, 0, 0);
    bit_in("c_bit", 1); bit_in("c_bit", 0); bit_in("c_bit", 1); bit_in("c_bit", 1);
    chk("c_match_old_pat", {7'd0, bus.match}, 8'd1);

    // Length-1 pattern saturates the counter; clear beats a simultaneous hit
    step("d_dis", 0, 0, 0, 8'h00, 3'd0, 0, 1, 0);
    step("d_cfg", 0, 0, 1, 8'h01, 3'd0, 0, 0, 1);
    step("d_arm", 0, 0, 0, 8'h00, 3'd0, 1, 0, 0);
    for (int i = 0; i < 16; i++) bit_in("d_one", 1);
    chk("d_sat", {4'd0, bus.count}, 8'h0F);
    chk("d_glyphF", {1'b0, bus.seg[6:0]}, 8'h71);
    step("d_clr_hit", 1, 1, 0, 8'h00, 3'd0, 0, 0, 1);
    chk("d_clr_match", {7'd0, bus.match}, 8'd1);
    chk("d_clr_count", {4'd0, bus.count}, 8'd0);

    // arm+disarm together, then no hit from stale history
    step("e_dis", 0, 0, 0, 8'h00, 3'd0, 0, 1, 0);
    step("e_cfg", 0, 0, 1, 8'h03, 3'd2, 0, 0, 0);
    step("e_arm", 0, 0, 0, 8'h00, 3'd0, 1, 0, 0);
    bit_in("e_pre", 0); bit_in("e_pre", 1);
    step("e_armdis", 0, 0, 0, 8'h00, 3'd0, 1, 1, 0);
    chk("e_idle", {7'd0, bus.armed}, 8'd0);
    step("e_rearm", 0, 0, 0, 8'h00, 3'd0, 1, 0, 0);
    bit_in("e_stale", 1);
    chk("e_no_stale", {7'd0, bus.match}, 8'd0);
    bit_in("e_seq", 0); bit_in("e_seq", 1); bit_in("e_seq", 1);
    chk("e_hit", {7'd0, bus.match}, 8'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      s2 = 8'($urandom);
      step("rnd", ($urandom_range(0, 3) != 0), s2[0], ($urandom_range(0, 9) == 0), 8'($urandom),
           3'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0));
      if (i == 300) reset_pulse("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
